div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage; consumes the decoder's isdiv/signeddiv controls as they arrive in E.
- Produces {HI=remainder, LO=quotient} for the HILO write port.
- Raises a stall to freeze the pipeline while iterating.
- Supports cancellation on flush/exception.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  divide request (isdiv of the E-stage instruction)
- signed_div  in  1  1 = DIV, 0 = DIVU; sampled with start
- opdata1  in  DATA_W  dividend (rs)
- opdata2  in  DATA_W  divisor (rt)
- annul  in  1  flush/exception cancel; aborts any operation
- stall_div  out  1  pipeline stall request
- ready  out  1  result valid, one-cycle pulse
- result  out  2*DATA_W  {remainder, quotient}

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: state = IDLE, counter = 0, result = 0, ready = 0, stall_div = 0.
- States: IDLE, DIVZERO, BUSY, DONE (encodings in the shared defines).
- IDLE, start=1, annul=0, divisor≠0:
  - latch |dividend|, |divisor|, quotient sign (sign1^sign2 & signed_div) and remainder sign (sign1 & signed_div);
  - go to BUSY; stall_div=1 combinationally in this cycle.
- IDLE, start=1, annul=0, divisor=0: go to DIVZERO; stall_div=1.
- IDLE, start=0 or annul=1: stay IDLE; stall_div=0.
- BUSY iteration, once per cycle for exactly DATA_W cycles:
  - partial = {rem, next dividend bit};
  - if partial ≥ divisor, subtract and shift in quotient 1, else shift in 0.
  - counter increments 0..DATA_W-1; leave BUSY after count DATA_W-1.
  - stall_div=1 throughout.
- End of BUSY → DONE:
  - apply signs: quotient negated if qsign, remainder negated if rsign;
  - register result; ready=1; stall_div=0.
- DIVZERO: one cycle with stall_div=1, then DONE with result = {dividend, all-ones}.
- DONE: lasts one cycle, then IDLE.
  - start is ignored in DONE, because the same instruction is still presenting it.
  - A new divide is accepted from IDLE in the following cycle.
- Latency: request at cycle T → stall_div high T..T+DATA_W, ready at T+DATA_W+1. Divide-by-zero: ready at T+2.
- annul in any state → IDLE next cycle. ready stays 0, result keeps its previous value, and stall_div drops in the annul cycle.
- result holds its value between DONE pulses; it changes only in DONE.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This falls out of magnitude arithmetic and is required.
- Arithmetic widths: comparator/subtractor is DATA_W+1 bits; magnitudes are computed as unsigned DATA_W values.
- resetn asserted mid-operation: immediate return to reset values; no partial result is exposed.

Decomposition:
- Shared defines: state encodings (DIV_IDLE, DIV_DIVZERO, DIV_BUSY, DIV_DONE) and the divider iteration count constant.
- One combinational sub-module, div_step: one restoring iteration (partial remainder, divisor → new remainder, quotient bit).
- FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- DIVU 100 / 7 → stall 33 cycles, ready pulse once, result = {0x00000002, 0x0000000E}.
- DIV 0xFFFFFF9C (−100) / 7 → result = {0xFFFFFFFE, 0xFFFFFFF2}. DIV 100 / −7 → {0x00000002, 0xFFFFFFF2}.
- DIV 0x80000000 / 0xFFFFFFFF → result = {0x00000000, 0x80000000}, no hang.
- DIVU 5 / 0 → ready at T+2, result = {0x00000005, 0xFFFFFFFF}.
- annul at BUSY cycle 10 → IDLE next cycle, stall_div 0, no ready pulse, result unchanged from the prior divide.
- Back-to-back: start held through DONE, then a new start → exactly two ready pulses, second result correct; resetn pulse mid-BUSY → all outputs 0 immediately.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle restoring divider: FSM state encodings
// and the default iteration count.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_BUSY    = 2'b10,
    DIV_DONE    = 2'b11
  } div_state_e;

  // One restoring iteration per quotient bit of a 32-bit operand.
  localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: compare the shifted partial remainder with
// the divisor, subtract when it fits and emit the quotient bit.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W:0]   i_partial,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_quot_bit
);

  logic [DATA_W-1:0] w_diff;

  // The incoming remainder is always below the divisor, so when the partial fits
  // the true difference is narrower than DATA_W and the truncated subtract is exact.
  always_comb begin
    o_quot_bit = (i_partial >= {1'b0, i_divisor});
    w_diff     = i_partial[DATA_W-1:0] - i_divisor;
    o_rem      = o_quot_bit ? w_diff : i_partial[DATA_W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Execute-stage radix-2 restoring divider producing {remainder, quotient} for HILO,
// stalling the pipeline while it iterates and honouring flush/exception annul.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_ITERS,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                annul,
  output logic                stall_div,
  output logic                ready,
  output logic [2*DATA_W-1:0] result
);

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_dvd;   // dividend magnitude; quotient bits shift in from the LSB
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   r_rem;
  logic                r_qsign;
  logic                r_rsign;
  logic [2*DATA_W-1:0] r_result;

  logic                w_div_zero;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic                w_last;
  logic [DATA_W-1:0]   w_step_rem;
  logic                w_step_q;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_quot_fix;
  logic [DATA_W-1:0]   w_rem_fix;

  always_comb begin
    w_div_zero = (opdata2 == '0);
    w_abs1     = (signed_div && opdata1[DATA_W-1]) ? (~opdata1 + 1'b1) : opdata1;
    w_abs2     = (signed_div && opdata2[DATA_W-1]) ? (~opdata2 + 1'b1) : opdata2;
    w_last     = (r_cnt == CNT_W'(DATA_W - 1));
    w_quot     = {r_dvd[DATA_W-2:0], w_step_q};
    w_quot_fix = r_qsign ? (~w_quot + 1'b1) : w_quot;
    w_rem_fix  = r_rsign ? (~w_step_rem + 1'b1) : w_step_rem;
  end

  div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .i_partial  ({r_rem, r_dvd[DATA_W-1]}),
    .i_divisor  (r_dvs),
    .o_rem      (w_step_rem),
    .o_quot_bit (w_step_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    stall_div   = 1'b0;
    ready       = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (start && !annul) begin
          stall_div   = 1'b1;
          w_state_nxt = w_div_zero ? DIV_DIVZERO : DIV_BUSY;
        end
      end
      DIV_DIVZERO: begin
        stall_div   = !annul;
        w_state_nxt = annul ? DIV_IDLE : DIV_DONE;
      end
      DIV_BUSY: begin
        stall_div = !annul;
        if (annul) begin
          w_state_nxt = DIV_IDLE;
        end else if (w_last) begin
          w_state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        // start is still the same instruction here, so it is deliberately ignored.
        ready       = !annul;
        w_state_nxt = DIV_IDLE;
      end
      default: w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (annul) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          DIV_IDLE: begin
            if (start) begin
              r_qsign <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
              r_rsign <= signed_div & opdata1[DATA_W-1];
              // Divide-by-zero reports the raw dividend, not its magnitude.
              r_dvd   <= w_div_zero ? opdata1 : w_abs1;
              r_dvs   <= w_abs2;
              r_rem   <= '0;
              r_cnt   <= '0;
            end
          end
          DIV_DIVZERO: begin
            r_result <= {r_dvd, {DATA_W{1'b1}}};
          end
          DIV_BUSY: begin
            r_rem <= w_step_rem;
            r_dvd <= w_quot;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= {w_rem_fix, w_quot_fix};
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign result = r_result;

endmodule
